// File: rtl/stream_minmax_u.sv
// Framed streaming reduction: per frame, tracks the unsigned min, the unsigned max and a
// saturating beat count, then holds one registered result until downstream takes it.
module stream_minmax_u #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_min,
  output logic [N-1:0]  out_max,
  output logic [CW-1:0] out_count,
  output logic          out_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  min_q, min_d;
  logic [N-1:0]  max_q, max_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          in_acc;

  assign in_ready = !rst && (state_q != DONE);
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_acc) begin
          min_d   = in_data;
          max_d   = in_data;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_acc) begin
          // Strict compares: ties leave the stored extreme untouched.
          if (in_data < min_q) min_d = in_data;
          if (max_q < in_data) max_d = in_data;
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_ONE;
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_stream_minmax_u.sv
// Directed bench for stream_minmax_u: a table of frames plus hand sequences for
// backpressure and reset. A second instance with CW=2 shares the inputs to exercise saturation.
module tb_stream_minmax_u;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_sat;
  logic [31:0] out_min, out_max;
  logic [15:0] out_count;
  logic        s_in_ready, s_out_valid, s_out_sat;
  logic [31:0] s_out_min, s_out_max;
  logic [1:0]  s_out_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_minmax_u #(.N(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
    .out_max(out_max), .out_count(out_count), .out_sat(out_sat)
  );

  stream_minmax_u #(.N(32), .CW(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready), .out_min(s_out_min),
    .out_max(s_out_max), .out_count(s_out_count), .out_sat(s_out_sat)
  );

  typedef struct {
    int              n;
    logic [5:0][31:0] d;
    int              gap;
    logic [31:0]     emin;
    logic [31:0]     emax;
    int              ecnt;
    logic            esat;
    int              scnt;
    logic            ssat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int n, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] d4,
                         input logic [31:0] d5, input int gap, input logic [31:0] emin,
                         input logic [31:0] emax, input int ecnt, input logic esat,
                         input int scnt, input logic ssat);
    vecs[i].n = n;
    vecs[i].d = {d5, d4, d3, d2, d1, d0};
    vecs[i].gap = gap;
    vecs[i].emin = emin; vecs[i].emax = emax;
    vecs[i].ecnt = ecnt; vecs[i].esat = esat;
    vecs[i].scnt = scnt; vecs[i].ssat = ssat;
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic beat(input logic [31:0] d, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("result_timeout", 64'(out_valid), 64'd1);
  endtask

  // Pulse out_ready for one edge, then confirm the bubble cycle behaviour.
  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] hmin, hmax;
    logic [15:0] hcnt;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;

    set_vec(0, 1, 32'd7, 0, 0, 0, 0, 0, 0, 32'd7, 32'd7, 1, 1'b0, 1, 1'b0);
    set_vec(1, 4, 32'd5, 32'd3, 32'd9, 32'd3, 0, 0, 2, 32'd3, 32'd9, 4, 1'b0, 3, 1'b1);
    set_vec(2, 5, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd1, 0, 0,
            32'd0, 32'hFFFFFFFF, 5, 1'b0, 3, 1'b1);
    set_vec(3, 4, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd1, 0, 0, 1,
            32'd1, 32'hFFFFFFFF, 4, 1'b0, 3, 1'b1);
    set_vec(4, 6, 32'd4, 32'd4, 32'd2, 32'd8, 32'd1, 32'd4, 0, 32'd1, 32'd8, 6, 1'b0, 3, 1'b1);
    set_vec(5, 1, 32'd42, 0, 0, 0, 0, 0, 0, 32'd42, 32'd42, 1, 1'b0, 1, 1'b0);
    set_vec(6, 3, 32'd5, 32'd5, 32'd5, 0, 0, 0, 1, 32'd5, 32'd5, 3, 1'b0, 3, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_min", 64'(out_min), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < vecs[i].n; b++) begin
        beat(vecs[i].d[b], (b == vecs[i].n - 1));
        if (b == vecs[i].n - 1)
          chk($sformatf("v%0d_latency", i), 64'(out_valid), 64'd1);
        else if (vecs[i].gap > 0)
          repeat (vecs[i].gap) @(posedge clk);
      end
      @(negedge clk);
      chk($sformatf("v%0d_min", i), 64'(out_min), 64'(vecs[i].emin));
      chk($sformatf("v%0d_max", i), 64'(out_max), 64'(vecs[i].emax));
      chk($sformatf("v%0d_count", i), 64'(out_count), 64'(vecs[i].ecnt));
      chk($sformatf("v%0d_sat", i), 64'(out_sat), 64'(vecs[i].esat));
      chk($sformatf("v%0d_s_count", i), 64'(s_out_count), 64'(vecs[i].scnt));
      chk($sformatf("v%0d_s_sat", i), 64'(s_out_sat), 64'(vecs[i].ssat));
      chk($sformatf("v%0d_ready_done", i), 64'(in_ready), 64'd0);
      take($sformatf("v%0d", i));
    end

    // Backpressure: result must hold while a new beat waits upstream
    beat(32'd11, 1'b0);
    beat(32'd2, 1'b1);
    wait_result();
    hmin = out_min; hmax = out_max; hcnt = out_count;
    chk("bp_min", 64'(hmin), 64'd2);
    chk("bp_max", 64'(hmax), 64'd11);
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold%0d_min", k), 64'(out_min), 64'd2);
      chk($sformatf("bp_hold%0d_max", k), 64'(out_max), 64'd11);
      chk($sformatf("bp_hold%0d_count", k), 64'(out_count), 64'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_released_valid", 64'(out_valid), 64'd0);
    chk("bp_released_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_min", 64'(out_min), 64'd99);
    chk("bp_next_max", 64'(out_max), 64'd99);
    chk("bp_next_count", 64'(out_count), 64'd1);
    take("bp_next");

    // Reset mid-frame discards the partial frame
    beat(32'd10, 1'b0);
    beat(32'd20, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_min_cleared", 64'(out_min), 64'd0);
    beat(32'd15, 1'b1);
    @(negedge clk);
    chk("mid_rst_res_valid", 64'(out_valid), 64'd1);
    chk("mid_rst_res_min", 64'(out_min), 64'd15);
    chk("mid_rst_res_max", 64'(out_max), 64'd15);
    chk("mid_rst_res_count", 64'(out_count), 64'd1);

    // Reset while DONE drops the untaken result
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("done_rst_valid", 64'(out_valid), 64'd0);
    chk("done_rst_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(32'd3, 1'b1);
    @(negedge clk);
    chk("after_rst_min", 64'(out_min), 64'd3);
    chk("after_rst_count", 64'(out_count), 64'd1);
    take("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_minmax_u.md
Name: stream_minmax_u

Overview:
- Streaming reduction stage that consumes framed N-bit unsigned samples over a valid/ready handshake.
- Per frame, tracks running minimum, maximum and beat count using unsigned less-than comparisons (sltu semantics).
- Presents one registered result per frame on an output valid/ready handshake.
- Sits directly downstream of the unsigned comparator datapath; it is the first sequential consumer of comparison results.

Parameters:
- N, 32, sample and min/max width in bits.
- CW, 16, beat counter width in bits.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, upstream sample valid.
- in_ready, output, 1, block accepts a sample this cycle.
- in_data, input, N, unsigned sample.
- in_last, input, 1, marks final sample of the frame; qualified by the input handshake.
- out_valid, output, 1, frame result valid.
- out_ready, input, 1, downstream accepts the result.
- out_min, output, N, smallest unsigned sample in the frame.
- out_max, output, N, largest unsigned sample in the frame.
- out_count, output, CW, number of samples in the frame, saturating.
- out_sat, output, 1, count saturated during this frame.

Behaviour:
- Interface: one clock domain (clk); rst is synchronous and active-high.
- Input handshake: a beat is accepted when in_valid && in_ready. Output handshake: a result is taken when out_valid && out_ready.
- States:
  - IDLE: no frame open; in_ready=1.
  - ACCUM: frame open; in_ready=1.
  - DONE: result held; in_ready=0, out_valid=1.
- in_ready is a combinational decode of the state, and is forced to 0 while rst is high.
- Transitions:
  - IDLE, accepted beat with in_last=0 -> ACCUM.
  - IDLE, accepted beat with in_last=1 -> DONE.
  - ACCUM, accepted beat with in_last=1 -> DONE; any other accepted beat stays in ACCUM.
  - DONE, output handshake -> IDLE.
  - No accepted beat: stay in the current state (in_valid gaps are legal anywhere).
- First beat of a frame (accepted in IDLE): min<=in_data, max<=in_data, count<=1, sat<=0.
- Each later accepted beat:
  - min<=in_data if in_data < min (unsigned).
  - max<=in_data if max < in_data (unsigned).
  - Ties leave min/max unchanged.
  - count<=count+1, saturating at 2^CW-1; an increment attempted at 2^CW-1 holds the count and sets sat<=1. sat is sticky until the next frame start.
- All comparisons are unsigned over full N bits; 2^N-1 is the largest value, never treated as -1.
- Latency:
  - out_valid rises the cycle after the in_last beat is accepted.
  - out_valid falls the cycle after the output handshake.
  - in_ready returns to 1 in that same cycle, so there is one unavoidable bubble cycle between frames.
- Hold: while out_valid=1 and out_ready=0, out_min, out_max, out_count and out_sat are stable; no input is accepted.
- Outputs are driven directly from registers; no combinational path from inputs to out_*.
- out_ready has no effect outside DONE.
- Reset (any state, including mid-frame or while DONE with result not taken):
  - state<=IDLE; min, max, count and sat registers <=0; out_valid=0.
  - Partial frames and untaken results are discarded.
  - First accepted beat after rst deasserts starts a fresh frame.
- Width rules: count and sat never wrap; min/max registers are exactly N bits.

Test Plan:
- Single-beat frame: in_data=7, in_last=1 accepted from IDLE -> next cycle out_valid=1, min=7, max=7, count=1, sat=0.
- Multi-beat frame with gaps: beats 5,3,9,3(last), in_valid low 2 cycles between 3 and 9 -> min=3, max=9, count=4; in_ready=0 while DONE; after out_ready=1 one cycle, out_valid=0 and in_ready=1 next cycle.
- Unsigned extremes (N=32): beats 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF, 0, 1(last) -> min=0, max=0xFFFFFFFF, count=5; repeat without the 0 beat -> min=1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE with in_valid=1 -> outputs stable, no beat accepted, frame count unchanged; release -> result taken, next frame starts with the pending beat.
- Saturation (CW=2): 6 beats 4,4,2,8,1,4(last) -> count=3, sat=1, min=1, max=8; next frame of 1 beat -> count=1, sat=0.
- Reset mid-frame: beats 10,20 accepted, rst high 1 cycle, then beat 15(last) -> out_valid=0 during/after reset until the frame completes; result min=15, max=15, count=1. Reset in DONE -> out_valid=0 the next cycle.
